// File: rtl/fetch_pkg.sv
// Shared types and constants for the program-counter / fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    FS_BOOT = 2'd0,
    FS_RUN  = 2'd1,
    FS_HALT = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    TC_NONE       = 2'd0,
    TC_MISALIGNED = 2'd1,
    TC_OOB        = 2'd2
  } trap_cause_e;

  localparam logic [31:0] IMEM_BASE = 32'h8000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC select with alignment and imem-window checks.
// Window check compiled in only when FETCH_BOUNDS_CHECK_EN is defined.
module fetch_next_pc
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = IMEM_BASE,
  parameter int unsigned IMEM_DEPTH   = 3000
) (
  input  logic [31:0] count,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] npc,
  output logic [31:0] pc_plus4,
  output trap_cause_e trap_cause
);

`ifdef FETCH_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  // 33-bit window so a step past 0xFFFF_FFFC lands above the window, not at 0.
  localparam logic [32:0] WIN_LO = {1'b0, RESET_VECTOR};
  localparam logic [32:0] WIN_HI = WIN_LO + 33'(4 * IMEM_DEPTH);

  logic [32:0] npc_wide;
  logic        in_window;

  always_comb begin
    pc_plus4 = count + PC_STEP;
    if (redirect_valid) begin
      npc_wide = {1'b0, redirect_target};
    end else begin
      npc_wide = {1'b0, count} + {1'b0, PC_STEP};
    end
    npc       = npc_wide[31:0];
    in_window = (npc_wide >= WIN_LO) && (npc_wide < WIN_HI);

    trap_cause = TC_NONE;
    if (redirect_valid && !is_word_aligned(redirect_target)) begin
      trap_cause = TC_MISALIGNED;
    end else if (BOUNDS_EN && !in_window) begin
      trap_cause = TC_OOB;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer feeding instruction_memory.
// Optional imem window trap: define FETCH_BOUNDS_CHECK_EN.
//
// state   | meaning
// BOOT    | post-reset delay, count held at RESET_VECTOR, no fetch
// RUN     | fetching; advance, stall, redirect, trap detection
// HALT    | terminal until reset; all state frozen
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = IMEM_BASE,
  parameter int unsigned IMEM_DEPTH   = 3000,
  parameter int unsigned BOOT_CYCLES  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        halt_req,
  output logic [31:0] count,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        trap_misaligned,
  output logic        trap_oob,
  output logic [31:0] trap_addr,
  output logic [1:0]  fsm_state,
  output logic [31:0] instret
);

  localparam int unsigned BOOT_W = (BOOT_CYCLES > 2) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BOOT_W-1:0] BOOT_LAST =
    (BOOT_CYCLES == 0) ? '0 : BOOT_W'(BOOT_CYCLES - 1);

  fetch_state_e      state_q, state_d;
  logic [31:0]       count_q, count_d;
  logic [BOOT_W-1:0] boot_cnt_q, boot_cnt_d;
  logic [31:0]       instret_q, instret_d;
  logic              trap_mis_q, trap_mis_d;
  logic              trap_oob_q, trap_oob_d;
  logic [31:0]       trap_addr_q, trap_addr_d;

  logic [31:0]       npc;
  trap_cause_e       trap_cause;
  logic              boot_done;

  fetch_next_pc #(
    .RESET_VECTOR (RESET_VECTOR),
    .IMEM_DEPTH   (IMEM_DEPTH)
  ) u_next_pc (
    .count           (count_q),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .npc             (npc),
    .pc_plus4        (pc_plus4),
    .trap_cause      (trap_cause)
  );

  assign boot_done = (BOOT_CYCLES == 0) || (boot_cnt_q == BOOT_LAST);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    boot_cnt_d  = boot_cnt_q;
    instret_d   = instret_q;
    trap_mis_d  = trap_mis_q;
    trap_oob_d  = trap_oob_q;
    trap_addr_d = trap_addr_q;

    case (state_q)
      FS_BOOT: begin
        if (halt_req) begin
          state_d = FS_HALT;
        end else if (boot_done) begin
          state_d = FS_RUN;
        end else begin
          boot_cnt_d = boot_cnt_q + BOOT_W'(1);
        end
      end

      FS_RUN: begin
        if (halt_req) begin
          state_d = FS_HALT;
        end else if (redirect_valid || !stall) begin
          case (trap_cause)
            TC_MISALIGNED: begin
              state_d     = FS_HALT;
              trap_mis_d  = 1'b1;
              trap_addr_d = redirect_target;
            end
            // The instruction that produced the bad PC still retires.
            TC_OOB: begin
              state_d     = FS_HALT;
              trap_oob_d  = 1'b1;
              trap_addr_d = npc;
              instret_d   = instret_q + 32'd1;
            end
            default: begin
              count_d   = npc;
              instret_d = instret_q + 32'd1;
            end
          endcase
        end
      end

      FS_HALT: begin
      end

      default: begin
        state_d = FS_HALT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FS_BOOT;
      count_q     <= RESET_VECTOR;
      boot_cnt_q  <= '0;
      instret_q   <= '0;
      trap_mis_q  <= 1'b0;
      trap_oob_q  <= 1'b0;
      trap_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      boot_cnt_q  <= boot_cnt_d;
      instret_q   <= instret_d;
      trap_mis_q  <= trap_mis_d;
      trap_oob_q  <= trap_oob_d;
      trap_addr_q <= trap_addr_d;
    end
  end

  assign count           = count_q;
  assign fetch_valid     = (state_q == FS_RUN);
  assign trap_misaligned = trap_mis_q;
  assign trap_oob        = trap_oob_q;
  assign trap_addr       = trap_addr_q;
  assign fsm_state       = state_q;
  assign instret         = instret_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: reference model plus directed literal checks.
module tb_pc_fetch_unit;

  localparam longint RV     = 64'h8000_0000;
  localparam longint WIN_HI = RV + 4 * 3000;
`ifdef FETCH_BOUNDS_CHECK_EN
  localparam bit BCHK = 1'b1;
`else
  localparam bit BCHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall, redirect_valid, halt_req;
  logic [31:0] redirect_target;
  logic [31:0] count, pc_plus4, trap_addr, instret;
  logic        fetch_valid, trap_misaligned, trap_oob;
  logic [1:0]  fsm_state;

  always #5 clk = ~clk;

  pc_fetch_unit #(
    .RESET_VECTOR (32'h8000_0000),
    .IMEM_DEPTH   (3000),
    .BOOT_CYCLES  (4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt_req        (halt_req),
    .count           (count),
    .pc_plus4        (pc_plus4),
    .fetch_valid     (fetch_valid),
    .trap_misaligned (trap_misaligned),
    .trap_oob        (trap_oob),
    .trap_addr       (trap_addr),
    .fsm_state       (fsm_state),
    .instret         (instret)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: state as 0/1/2, boot tracked as edges spent in BOOT.
  logic [31:0] m_pc, m_instret, m_taddr;
  int          m_state, m_boot;
  bit          m_mis, m_oob;

  function automatic bit out_of_window(input longint n);
    return BCHK && (n < RV || n >= WIN_HI);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= 32'h8000_0000; m_instret <= 0; m_taddr <= 0;
      m_state <= 0; m_boot <= 0; m_mis <= 0; m_oob <= 0;
    end else if (m_state == 0) begin
      if (halt_req) m_state <= 2;
      else if (m_boot + 1 >= 4) m_state <= 1;
      else m_boot <= m_boot + 1;
    end else if (m_state == 1) begin
      if (halt_req) begin
        m_state <= 2;
      end else if (redirect_valid && (redirect_target % 4 != 0)) begin
        m_state <= 2; m_mis <= 1; m_taddr <= redirect_target;
      end else if (redirect_valid) begin
        m_instret <= m_instret + 1;
        if (out_of_window(longint'({32'h0, redirect_target}))) begin
          m_state <= 2; m_oob <= 1; m_taddr <= redirect_target;
        end else m_pc <= redirect_target;
      end else if (!stall) begin
        m_instret <= m_instret + 1;
        if (out_of_window(longint'({32'h0, m_pc}) + 4)) begin
          m_state <= 2; m_oob <= 1; m_taddr <= m_pc + 4;
        end else m_pc <= m_pc + 4;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_count", count, m_pc);
      chk("m_pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("m_fetch_valid", 32'(fetch_valid), 32'(m_state == 1));
      chk("m_fsm_state", 32'(fsm_state), 32'(m_state));
      chk("m_trap_mis", 32'(trap_misaligned), 32'(m_mis));
      chk("m_trap_oob", 32'(trap_oob), 32'(m_oob));
      chk("m_trap_addr", trap_addr, m_taddr);
      chk("m_instret", instret, m_instret);
    end
  end

  // Leaves the DUT in RUN at count=RESET_VECTOR, instret=0.
  task automatic do_reset();
    @(negedge clk); #2 rst_n = 1'b0;
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    stall = 0; redirect_valid = 0; redirect_target = 0; halt_req = 0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_count", count, 32'h8000_0000);
    chk("rst_fv", 32'(fetch_valid), 0);
    chk("rst_state", 32'(fsm_state), 0);
    chk("rst_instret", instret, 0);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("boot_fv", 32'(fetch_valid), 0);
      chk("boot_count", count, 32'h8000_0000);
    end
    @(negedge clk);
    chk("run_state", 32'(fsm_state), 1);
    chk("run_count0", count, 32'h8000_0000);
    @(negedge clk); chk("seq1", count, 32'h8000_0004);
    @(negedge clk); chk("seq2", count, 32'h8000_0008);
    chk("instret2", instret, 2);
    repeat (2) @(negedge clk);
    chk("seq4", count, 32'h8000_0010);

    stall = 1;
    repeat (3) @(negedge clk);
    chk("stall_count", count, 32'h8000_0010);
    chk("stall_instret", instret, 4);
    stall = 0;
    @(negedge clk); chk("unstall_count", count, 32'h8000_0014);
    chk("unstall_instret", instret, 5);

    redirect_valid = 1; redirect_target = 32'h8000_0100; stall = 1;
    @(negedge clk); chk("redir_stall_count", count, 32'h8000_0100);
    chk("redir_stall_instret", instret, 6);
    redirect_target = 32'h8000_0040; stall = 0;
    @(negedge clk); chk("redir40", count, 32'h8000_0040);
    redirect_valid = 0;

    #2 rst_n = 1'b0;
    #1;
    chk("async_count", count, 32'h8000_0000);
    chk("async_instret", instret, 0);
    chk("async_state", 32'(fsm_state), 0);
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("reboot_state", 32'(fsm_state), 1);

    redirect_valid = 1; redirect_target = 32'h8000_0102;
    @(negedge clk);
    chk("mis_state", 32'(fsm_state), 2);
    chk("mis_flag", 32'(trap_misaligned), 1);
    chk("mis_addr", trap_addr, 32'h8000_0102);
    chk("mis_count", count, 32'h8000_0000);
    chk("mis_instret", instret, 0);
    redirect_target = 32'h8000_0200; halt_req = 1; stall = 1;
    repeat (2) @(negedge clk);
    redirect_valid = 0; halt_req = 0; stall = 0;
    repeat (3) @(negedge clk);
    chk("halt_frozen_count", count, 32'h8000_0000);
    chk("halt_frozen_addr", trap_addr, 32'h8000_0102);
    chk("halt_fv", 32'(fetch_valid), 0);

    do_reset();
    @(negedge clk);
    halt_req = 1;
    @(negedge clk); halt_req = 0;
    chk("halt_run_state", 32'(fsm_state), 2);
    chk("halt_run_count", count, 32'h8000_0004);
    chk("halt_run_instret", instret, 1);

    @(negedge clk); #2 rst_n = 1'b0;
    @(negedge clk); #2 rst_n = 1'b1; halt_req = 1;
    @(negedge clk); halt_req = 0;
    repeat (4) @(negedge clk);
    chk("halt_boot_state", 32'(fsm_state), 2);

    do_reset();
    redirect_valid = 1; redirect_target = 32'h0000_0001;
    @(negedge clk); redirect_valid = 0;
    chk("mis_prio_flag", 32'(trap_misaligned), 1);
    chk("mis_prio_oob", 32'(trap_oob), 0);

    do_reset();
    redirect_valid = 1; redirect_target = 32'h8000_2ED8;
    @(negedge clk); redirect_valid = 0;
    chk("edge_count", count, 32'h8000_2ED8);
    @(negedge clk); chk("last_count", count, 32'h8000_2EDC);
    @(negedge clk);
    chk("past_instret", instret, 3);
`ifdef FETCH_BOUNDS_CHECK_EN
    chk("oob_seq_flag", 32'(trap_oob), 1);
    chk("oob_seq_addr", trap_addr, 32'h8000_2EE0);
    chk("oob_seq_count", count, 32'h8000_2EDC);
`else
    chk("nochk_seq_count", count, 32'h8000_2EE0);
`endif

    do_reset();
    redirect_valid = 1; redirect_target = 32'h7FFF_FFFC;
    @(negedge clk); redirect_valid = 0;
`ifdef FETCH_BOUNDS_CHECK_EN
    chk("oob_low_flag", 32'(trap_oob), 1);
    chk("oob_low_addr", trap_addr, 32'h7FFF_FFFC);
`else
    chk("nochk_low_count", count, 32'h7FFF_FFFC);
    chk("nochk_low_oob", 32'(trap_oob), 0);
`endif

    do_reset();
    redirect_valid = 1; redirect_target = 32'hFFFF_FFFC;
    @(negedge clk); redirect_valid = 0;
    @(negedge clk);
`ifdef FETCH_BOUNDS_CHECK_EN
    chk("oob_top_addr", trap_addr, 32'hFFFF_FFFC);
`else
    chk("wrap_count", count, 32'h0000_0000);
    chk("wrap_fv", 32'(fetch_valid), 1);
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
